// File: rtl/fp_result_collector.sv
// ---------------------------------------------------------------------------
// fp_result_collector
//   Receiving end of the floating-point multiplier result stream. Every
//   validIn beat is captured into a first-word-fall-through FIFO that the
//   consumer drains with a pop handshake. Dropped beats and IEEE-754 binary32
//   special values (NaN, Inf, zero/subnormal) are reported as sticky status.
//
// Ports
//   clkIn        in   1        single clock, rising edge
//   rstIn        in   1        asynchronous reset, active low
//   validIn      in   1        result beat valid (producer cannot be stalled)
//   dataIn       in   WIDTH    binary32 result
//   readIn       in   1        pop request from consumer
//   clearIn      in   1        synchronous flush and status clear
//   dataOut      out  WIDTH    FIFO head, 0 while empty
//   validOut     out  1        FIFO not empty
//   countOut     out  CW       occupancy 0..DEPTH
//   overflowOut  out  1        sticky: a beat was dropped
//   dropCountOut out  16       dropped beats, saturating
//   flagsOut     out  3        sticky: [0] NaN, [1] Inf, [2] zero/subnormal
// ---------------------------------------------------------------------------
module fp_result_collector #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                       clkIn,
  input  logic                       rstIn,
  input  logic                       validIn,
  input  logic [WIDTH-1:0]           dataIn,
  input  logic                       readIn,
  input  logic                       clearIn,
  output logic [WIDTH-1:0]           dataOut,
  output logic                       validOut,
  output logic [$clog2(DEPTH):0]     countOut,
  output logic                       overflowOut,
  output logic [15:0]                dropCountOut,
  output logic [2:0]                 flagsOut
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

  logic [WIDTH-1:0] memQ [DEPTH];

  logic [AW-1:0] wrPtrQ, wrPtrD;
  logic [AW-1:0] rdPtrQ, rdPtrD;
  logic [CW-1:0] countQ, countD;
  logic          overflowQ, overflowD;
  logic [15:0]   dropCountQ, dropCountD;
  logic [2:0]    flagsQ, flagsD;

  logic          pop;
  logic          push;
  logic          memWe;
  logic [7:0]    expField;
  logic [22:0]   manField;
  logic [2:0]    beatFlags;

  // Classify the incoming word as a binary32 value. Every validIn beat is
  // classified, including beats that end up being dropped.
  always_comb begin
    expField     = dataIn[30:23];
    manField     = dataIn[22:0];
    beatFlags    = 3'b000;
    beatFlags[0] = (expField == 8'hFF) && (manField != 23'd0);
    beatFlags[1] = (expField == 8'hFF) && (manField == 23'd0);
    beatFlags[2] = (expField == 8'h00);
  end

  // Handshake and next-state logic. A pop frees a slot in the same cycle, so
  // a full FIFO can accept a beat while it is being read. clearIn overrides
  // everything that would otherwise happen this cycle.
  always_comb begin
    pop        = readIn && (countQ != '0);
    push       = validIn && ((countQ < DepthC) || pop);
    memWe      = 1'b0;
    wrPtrD     = wrPtrQ;
    rdPtrD     = rdPtrQ;
    countD     = countQ;
    overflowD  = overflowQ;
    dropCountD = dropCountQ;
    flagsD     = flagsQ;

    if (clearIn) begin
      wrPtrD     = '0;
      rdPtrD     = '0;
      countD     = '0;
      overflowD  = 1'b0;
      dropCountD = '0;
      flagsD     = 3'b000;
    end else begin
      memWe = push;
      if (push) begin
        wrPtrD = wrPtrQ + AW'(1);
      end
      if (pop) begin
        rdPtrD = rdPtrQ + AW'(1);
      end
      if (push && !pop) begin
        countD = countQ + CW'(1);
      end else if (pop && !push) begin
        countD = countQ - CW'(1);
      end
      if (validIn) begin
        flagsD = flagsQ | beatFlags;
      end
      if (validIn && !push) begin
        overflowD = 1'b1;
        if (dropCountQ != 16'hFFFF) begin
          dropCountD = dropCountQ + 16'd1;
        end
      end
    end
  end

  // Control and status registers; all lost immediately on reset.
  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      wrPtrQ     <= '0;
      rdPtrQ     <= '0;
      countQ     <= '0;
      overflowQ  <= 1'b0;
      dropCountQ <= '0;
      flagsQ     <= 3'b000;
    end else begin
      wrPtrQ     <= wrPtrD;
      rdPtrQ     <= rdPtrD;
      countQ     <= countD;
      overflowQ  <= overflowD;
      dropCountQ <= dropCountD;
      flagsQ     <= flagsD;
    end
  end

  // Storage has no reset: stale entries are never visible because the head
  // output is gated by the occupancy count.
  always_ff @(posedge clkIn) begin
    if (memWe) begin
      memQ[wrPtrQ] <= dataIn;
    end
  end

  assign validOut     = (countQ != '0);
  assign dataOut      = validOut ? memQ[rdPtrQ] : '0;
  assign countOut     = countQ;
  assign overflowOut  = overflowQ;
  assign dropCountOut = dropCountQ;
  assign flagsOut     = flagsQ;

endmodule

// File: tb/tb_fp_result_collector.sv
// ---------------------------------------------------------------------------
// tb_fp_result_collector
//   Self-checking bench for fp_result_collector. A queue-based reference
//   model tracks the expected FIFO contents and sticky status; a monitor
//   compares every output shortly after each rising edge. Directed scenarios
//   pin the model with literal expectations, then a randomized phase runs.
// ---------------------------------------------------------------------------
module tb_fp_result_collector;

  localparam int DEPTH = 16;
  localparam int WIDTH = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clkIn;
  logic             rstIn;
  logic             validIn;
  logic [WIDTH-1:0] dataIn;
  logic             readIn;
  logic             clearIn;
  logic [WIDTH-1:0] dataOut;
  logic             validOut;
  logic [CW-1:0]    countOut;
  logic             overflowOut;
  logic [15:0]      dropCountOut;
  logic [2:0]       flagsOut;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] modelQ[$];
  logic        modelOvf  = 1'b0;
  logic [15:0] modelDrop = 16'd0;
  logic [2:0]  modelFlags = 3'b000;
  logic        modelPop;
  logic        modelPush;

  fp_result_collector #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clkIn        (clkIn),
    .rstIn        (rstIn),
    .validIn      (validIn),
    .dataIn       (dataIn),
    .readIn       (readIn),
    .clearIn      (clearIn),
    .dataOut      (dataOut),
    .validOut     (validOut),
    .countOut     (countOut),
    .overflowOut  (overflowOut),
    .dropCountOut (dropCountOut),
    .flagsOut     (flagsOut)
  );

  initial clkIn = 1'b0;
  always #5 clkIn = ~clkIn;

  // Single comparison point: every check goes through here.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] classify(input logic [31:0] w);
    logic [7:0]  e;
    logic [22:0] m;
    e = w[30:23];
    m = w[22:0];
    return {e == 8'h00, (e == 8'hFF) && (m == 0), (e == 8'hFF) && (m != 0)};
  endfunction

  // Model: queue semantics straight from the handshake rules.
  always @(posedge clkIn) begin
    if (rstIn === 1'b1) begin
      if (clearIn) begin
        modelQ.delete();
        modelOvf   = 1'b0;
        modelDrop  = 16'd0;
        modelFlags = 3'b000;
      end else begin
        modelPop  = readIn && (modelQ.size() > 0);
        modelPush = validIn && ((modelQ.size() < DEPTH) || modelPop);
        if (validIn) modelFlags = modelFlags | classify(dataIn);
        if (validIn && !modelPush) begin
          modelOvf = 1'b1;
          if (modelDrop != 16'hFFFF) modelDrop = modelDrop + 16'd1;
        end
        if (modelPop) void'(modelQ.pop_front());
        if (modelPush) modelQ.push_back(dataIn);
      end
    end
  end

  // Asynchronous reset wipes model state immediately.
  always @(negedge rstIn) begin
    modelQ.delete();
    modelOvf   = 1'b0;
    modelDrop  = 16'd0;
    modelFlags = 3'b000;
  end

  // Monitor: compare all outputs against the model after each edge settles.
  always @(posedge clkIn) begin
    #2;
    checkOutput("mon.validOut", 32'(validOut), 32'(modelQ.size() > 0));
    checkOutput("mon.countOut", 32'(countOut), 32'(modelQ.size()));
    if (modelQ.size() > 0)
      checkOutput("mon.dataOut", dataOut, modelQ[0]);
    else
      checkOutput("mon.dataOutEmpty", dataOut, 32'h0);
    checkOutput("mon.overflowOut", 32'(overflowOut), 32'(modelOvf));
    checkOutput("mon.dropCountOut", 32'(dropCountOut), 32'(modelDrop));
    checkOutput("mon.flagsOut", 32'(flagsOut), 32'(modelFlags));
  end

  task automatic applyStimulus(input logic v, input logic [31:0] d,
                               input logic r, input logic c);
    @(negedge clkIn);
    validIn = v;
    dataIn  = d;
    readIn  = r;
    clearIn = c;
  endtask

  // Wait for the edge that consumes the last applied stimulus.
  task automatic settle();
    @(posedge clkIn);
    #3;
  endtask

  function automatic logic [31:0] randWord();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 5))
      0: w[30:23] = 8'hFF;
      1: begin w[30:23] = 8'hFF; w[22:0] = '0; end
      2: w[30:23] = 8'h00;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    rstIn   = 1'b0;
    validIn = 1'b0;
    dataIn  = '0;
    readIn  = 1'b0;
    clearIn = 1'b0;

    // Reset state
    #12;
    checkOutput("reset.countOut", 32'(countOut), 32'd0);
    checkOutput("reset.validOut", 32'(validOut), 32'd0);
    checkOutput("reset.dataOut", dataOut, 32'h0);
    checkOutput("reset.flagsOut", 32'(flagsOut), 32'd0);
    @(negedge clkIn);
    rstIn = 1'b1;

    // Three pushes, then drain in order
    applyStimulus(1, 32'h3F800000, 0, 0);
    applyStimulus(1, 32'h40000000, 0, 0);
    applyStimulus(1, 32'hC0400000, 0, 0);
    applyStimulus(0, 32'h0, 0, 0);
    settle();
    checkOutput("t1.countOut", 32'(countOut), 32'd3);
    checkOutput("t1.dataOut", dataOut, 32'h3F800000);
    applyStimulus(0, 32'h0, 1, 0);
    settle();
    checkOutput("t1.pop1.dataOut", dataOut, 32'h40000000);
    applyStimulus(0, 32'h0, 1, 0);
    settle();
    checkOutput("t1.pop2.dataOut", dataOut, 32'hC0400000);
    applyStimulus(0, 32'h0, 1, 0);
    settle();
    checkOutput("t1.pop3.countOut", 32'(countOut), 32'd0);

    // Seventeen pushes into a 16-deep FIFO
    for (int i = 0; i < 17; i++)
      applyStimulus(1, 32'h41000000 + 32'(i), 0, 0);
    applyStimulus(0, 32'h0, 0, 0);
    settle();
    checkOutput("t2.countOut", 32'(countOut), 32'd16);
    checkOutput("t2.overflowOut", 32'(overflowOut), 32'd1);
    checkOutput("t2.dropCountOut", 32'(dropCountOut), 32'd1);
    checkOutput("t2.head", dataOut, 32'h41000000);

    // Full with simultaneous push and pop across pointer wrap
    for (int i = 0; i < 20; i++)
      applyStimulus(1, 32'h42000000 + 32'(i), 1, 0);
    applyStimulus(0, 32'h0, 0, 0);
    settle();
    checkOutput("t3.countOut", 32'(countOut), 32'd16);
    checkOutput("t3.dropCountOut", 32'(dropCountOut), 32'd1);
    checkOutput("t3.head", dataOut, 32'h42000004);

    // Sticky flags, then clear
    applyStimulus(1, 32'h0, 0, 1);
    applyStimulus(1, 32'h7FC00000, 0, 0);
    settle();
    checkOutput("t4.nan", 32'(flagsOut), 32'b001);
    applyStimulus(1, 32'h7F800000, 0, 0);
    settle();
    checkOutput("t4.inf", 32'(flagsOut), 32'b011);
    applyStimulus(1, 32'h00000000, 0, 0);
    settle();
    checkOutput("t4.zero", 32'(flagsOut), 32'b111);
    applyStimulus(1, 32'h7FC00000, 1, 1);
    settle();
    checkOutput("t4.clr.flagsOut", 32'(flagsOut), 32'd0);
    checkOutput("t4.clr.countOut", 32'(countOut), 32'd0);
    checkOutput("t4.clr.validOut", 32'(validOut), 32'd0);

    // Read while empty, then push+read while empty
    applyStimulus(0, 32'h0, 1, 0);
    applyStimulus(0, 32'h0, 1, 0);
    settle();
    checkOutput("t5.countOut", 32'(countOut), 32'd0);
    applyStimulus(1, 32'h3F000000, 1, 0);
    settle();
    checkOutput("t5.pushread.countOut", 32'(countOut), 32'd1);
    checkOutput("t5.pushread.dataOut", dataOut, 32'h3F000000);

    // Build count=5 with overflow set, then reset between edges
    applyStimulus(0, 32'h0, 0, 1);
    for (int i = 0; i < 17; i++)
      applyStimulus(1, 32'h43000000 + 32'(i), 0, 0);
    for (int i = 0; i < 11; i++)
      applyStimulus(0, 32'h0, 1, 0);
    applyStimulus(0, 32'h0, 0, 0);
    settle();
    checkOutput("t6.pre.countOut", 32'(countOut), 32'd5);
    checkOutput("t6.pre.overflowOut", 32'(overflowOut), 32'd1);
    @(negedge clkIn);
    #1;
    rstIn = 1'b0;
    validIn = 1'b1;
    dataIn  = 32'h7FC00000;
    #1;
    checkOutput("t6.rst.countOut", 32'(countOut), 32'd0);
    checkOutput("t6.rst.validOut", 32'(validOut), 32'd0);
    checkOutput("t6.rst.dataOut", dataOut, 32'h0);
    checkOutput("t6.rst.overflowOut", 32'(overflowOut), 32'd0);
    checkOutput("t6.rst.dropCountOut", 32'(dropCountOut), 32'd0);
    checkOutput("t6.rst.flagsOut", 32'(flagsOut), 32'd0);
    repeat (2) @(posedge clkIn);
    @(negedge clkIn);
    rstIn = 1'b1;
    validIn = 1'b0;
    applyStimulus(1, 32'h3FC00000, 0, 0);
    applyStimulus(0, 32'h0, 0, 0);
    settle();
    checkOutput("t6.resume.countOut", 32'(countOut), 32'd1);
    checkOutput("t6.resume.dataOut", dataOut, 32'h3FC00000);

    // Randomized traffic checked by the monitor
    for (int i = 0; i < 3000; i++)
      applyStimulus(($urandom_range(0, 9) < 6), randWord(),
                    ($urandom_range(0, 9) < 5), ($urandom_range(0, 99) == 0));
    applyStimulus(0, 32'h0, 0, 0);
    settle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
